digit_entry_ctrl: RTL and testbench

- Sequences handwritten-digit entry between the mouse drawing capture stage, the digit recognizer and the 81-cell Sudoku board store.
- Accepts one completed stroke capture (cell index plus 52x52 bitmap) and checks it against the board's locked (given) cells.
- Launches the recognizer with a start/done handshake, guards it with a timeout, and commits the recognized digit to the board write port.
- Holds one pending capture while busy, so a stroke finished during recognition is not lost.

---
 rtl/sudoku_pkg.sv | 21 ++
 rtl/digit_entry_ctrl_if.sv | 36 +++
 rtl/capture_slot.sv | 34 +++
 rtl/digit_entry_ctrl.sv | 153 +++++++++++++++
 tb/tb_digit_entry_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sudoku_pkg.sv
// Shared board dimensions and controller state encoding for the digit entry path.
package sudoku_pkg;

  localparam int CELLS   = 81;
  localparam int POS_W   = 7;
  localparam int TRACK_W = 2704;
  localparam int DIGIT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    LAUNCH,
    WAIT,
    COMMIT
  } state_t;

  function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
    return (d >= DIGIT_W'(1)) && (d <= DIGIT_W'(9));
  endfunction

endpackage

// File: rtl/digit_entry_ctrl_if.sv
// Capture, lock, recognizer and board-write signals of the digit entry controller.
interface digit_entry_ctrl_if;
  import sudoku_pkg::*;

  logic               cap_valid;
  logic [POS_W-1:0]   cap_pos;
  logic [TRACK_W-1:0] cap_track;
  logic               lock_load;
  logic [CELLS-1:0]   lock_mask;
  logic               rec_start;
  logic [TRACK_W-1:0] rec_track;
  logic               rec_done;
  logic [DIGIT_W-1:0] rec_digit;
  logic               wr_en;
  logic [POS_W-1:0]   wr_addr;
  logic [DIGIT_W-1:0] wr_data;
  logic               busy;
  logic               err_range;
  logic               err_locked;
  logic               err_reject;
  logic               err_timeout;
  logic               overrun;

  modport master (
    input  cap_valid, cap_pos, cap_track, lock_load, lock_mask, rec_done, rec_digit,
    output rec_start, rec_track, wr_en, wr_addr, wr_data, busy,
           err_range, err_locked, err_reject, err_timeout, overrun
  );

  modport slave (
    output cap_valid, cap_pos, cap_track, lock_load, lock_mask, rec_done, rec_digit,
    input  rec_start, rec_track, wr_en, wr_addr, wr_data, busy,
           err_range, err_locked, err_reject, err_timeout, overrun
  );

endinterface

// File: rtl/capture_slot.sv
// One-entry holding register for a capture that arrives while the controller is busy.
module capture_slot
  import sudoku_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  logic [POS_W-1:0]   wr_pos,
  input  logic [TRACK_W-1:0] wr_track,
  input  logic               consume,
  output logic               full,
  output logic [POS_W-1:0]   pos,
  output logic [TRACK_W-1:0] track,
  output logic               overrun
);

  // A write in the same cycle the entry is consumed is a refill, not a loss.
  assign overrun = wr & full & ~consume;

  always_ff @(posedge clk) begin
    if (rst) begin
      full  <= 1'b0;
      pos   <= '0;
      track <= '0;
    end else if (wr) begin
      full  <= 1'b1;
      pos   <= wr_pos;
      track <= wr_track;
    end else if (consume) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/digit_entry_ctrl.sv
// Sequences stroke capture -> lock/range check -> recognizer -> board write.
// Define BLANK_ERASE_EN to let an empty stroke erase its cell without the recognizer.
module digit_entry_ctrl
  import sudoku_pkg::*;
#(
  parameter int TIMEOUT = 1000000
) (
  input logic                clk,
  input logic                rst,
  digit_entry_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int EXT_W = 2 ** POS_W;

  state_t             state;
  state_t             state_next;
  logic [POS_W-1:0]   pos_q;
  logic [TRACK_W-1:0] track_q;
  logic [DIGIT_W-1:0] digit_q;
  logic [CELLS-1:0]   lock_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [EXT_W-1:0]   lock_ext;

  logic               slot_wr;
  logic               slot_consume;
  logic               slot_full;
  logic               slot_overrun;
  logic [POS_W-1:0]   slot_pos;
  logic [TRACK_W-1:0] slot_track;

  logic idle;
  logic in_range;
  logic locked;
  logic timed_out;

  assign idle         = (state == IDLE);
  assign slot_wr      = bus.cap_valid & (~idle | slot_full);
  assign slot_consume = idle & slot_full;
  assign in_range     = pos_q < POS_W'(CELLS);
  assign lock_ext     = {{(EXT_W - CELLS){1'b0}}, lock_q};
  assign locked       = lock_ext[pos_q];
  assign timed_out    = cnt_q == CNT_W'(TIMEOUT - 1);
  assign bus.rec_track = track_q;

  capture_slot u_slot (
    .clk      (clk),
    .rst      (rst),
    .wr       (slot_wr),
    .wr_pos   (bus.cap_pos),
    .wr_track (bus.cap_track),
    .consume  (slot_consume),
    .full     (slot_full),
    .pos      (slot_pos),
    .track    (slot_track),
    .overrun  (slot_overrun)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q   <= '0;
      track_q <= '0;
      digit_q <= '0;
      lock_q  <= '0;
      cnt_q   <= '0;
    end else begin
      if (bus.lock_load) lock_q <= bus.lock_mask;
      // The held capture is older, so it is serviced before a fresh one.
      if (idle) begin
        if (slot_full) begin
          pos_q   <= slot_pos;
          track_q <= slot_track;
        end else if (bus.cap_valid) begin
          pos_q   <= bus.cap_pos;
          track_q <= bus.cap_track;
        end
      end
      if (state == LAUNCH)    cnt_q <= '0;
      else if (state == WAIT) cnt_q <= cnt_q + CNT_W'(1);
      if (state == WAIT && bus.rec_done && digit_ok(bus.rec_digit)) digit_q <= bus.rec_digit;
`ifdef BLANK_ERASE_EN
      if (state == CHECK) digit_q <= '0;
`endif
    end
  end

  always_comb begin
    state_next      = state;
    bus.rec_start   = 1'b0;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.busy        = 1'b0;
    bus.err_range   = 1'b0;
    bus.err_locked  = 1'b0;
    bus.err_reject  = 1'b0;
    bus.err_timeout = 1'b0;
    bus.overrun     = 1'b0;
    // Outputs are forced quiet while reset is held, even before the state clears.
    if (!rst) begin
      bus.busy    = ~idle;
      bus.overrun = slot_overrun;
      case (state)
        IDLE: if (slot_full || bus.cap_valid) state_next = CHECK;
        CHECK: begin
          if (!in_range) begin
            bus.err_range = 1'b1;
            state_next    = IDLE;
          end else if (locked) begin
            bus.err_locked = 1'b1;
            state_next     = IDLE;
`ifdef BLANK_ERASE_EN
          end else if (track_q == '0) begin
            state_next = COMMIT;
`endif
          end else begin
            state_next = LAUNCH;
          end
        end
        LAUNCH: begin
          bus.rec_start = 1'b1;
          state_next    = WAIT;
        end
        WAIT: begin
          if (bus.rec_done) begin
            if (digit_ok(bus.rec_digit)) begin
              state_next = COMMIT;
            end else begin
              bus.err_reject = 1'b1;
              state_next     = IDLE;
            end
          end else if (timed_out) begin
            bus.err_timeout = 1'b1;
            state_next      = IDLE;
          end
        end
        COMMIT: begin
          bus.wr_en   = 1'b1;
          bus.wr_addr = pos_q;
          bus.wr_data = digit_q;
          state_next  = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// Randomized scoreboard bench for digit_entry_ctrl: a job-level model predicts every output event.
module tb_digit_entry_ctrl;
  import sudoku_pkg::*;

  localparam int TMO = 16;
`ifdef BLANK_ERASE_EN
  localparam bit ERASE = 1'b1;
`else
  localparam bit ERASE = 1'b0;
`endif
  localparam int K_START = 0, K_WR = 1, K_RANGE = 2, K_LOCKED = 3,
                 K_REJECT = 4, K_TIMEOUT = 5, K_OVERRUN = 6;

  typedef struct { int cyc; int kind; int addr; int data; logic [TRACK_W-1:0] track; } exp_t;
  typedef struct { int pos; logic [TRACK_W-1:0] track; int digit; int delay; bit silent; } job_t;
  typedef struct { int delay; int digit; bit silent; } plan_t;

  logic clk = 1'b0;
  logic rst;
  digit_entry_ctrl_if bus ();

  digit_entry_ctrl #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t             exp_q[$];
  plan_t            plan_q[$];
  int               checks = 0;
  int               failures = 0;
  logic [CELLS-1:0] lock_model;
  int               idle_at;
  bit               slot_full_m;
  job_t             slot_job;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, actual, required);
    end
  endtask

  function automatic void push_exp(input int c, input int kind, input int addr, input int data,
                                   input logic [TRACK_W-1:0] tr);
    exp_t e;
    int   i;
    e = '{cyc: c, kind: kind, addr: addr, data: data, track: tr};
    i = 0;
    while (i < exp_q.size() && (exp_q[i].cyc < c || (exp_q[i].cyc == c && exp_q[i].kind <= kind))) i++;
    exp_q.insert(i, e);
  endfunction

  // Outcome of one capture first seen by an idle controller in cycle t; returns its last busy cycle.
  function automatic int predict(input int t, input job_t j);
    int launch;
    if (j.pos >= CELLS) begin
      push_exp(t + 1, K_RANGE, j.pos, 0, '0);
      return t + 1;
    end
    if (lock_model[j.pos]) begin
      push_exp(t + 1, K_LOCKED, j.pos, 0, '0);
      return t + 1;
    end
    if (ERASE && j.track == '0) begin
      push_exp(t + 2, K_WR, j.pos, 0, '0);
      return t + 2;
    end
    launch = t + 2;
    push_exp(launch, K_START, j.pos, 0, j.track);
    plan_q.push_back('{delay: j.delay, digit: j.digit, silent: j.silent});
    if (j.silent) begin
      push_exp(launch + TMO, K_TIMEOUT, j.pos, 0, '0);
      return launch + TMO;
    end
    if (j.digit >= 1 && j.digit <= 9) begin
      push_exp(launch + j.delay + 1, K_WR, j.pos, j.digit, '0);
      return launch + j.delay + 1;
    end
    push_exp(launch + j.delay, K_REJECT, j.pos, 0, '0);
    return launch + j.delay;
  endfunction

  function automatic void capture_model(input int c, input job_t j);
    if (c >= idle_at && !slot_full_m) begin
      idle_at = predict(c, j) + 1;
    end else begin
      if (slot_full_m) push_exp(c, K_OVERRUN, 0, 0, '0);
      slot_job    = j;
      slot_full_m = 1'b1;
    end
  endfunction

  function automatic void drain();
    if (slot_full_m) begin
      slot_full_m = 1'b0;
      idle_at     = predict(idle_at, slot_job) + 1;
    end
  endfunction

  function automatic job_t mk(input int pos, input int digit, input int delay, input bit silent, input bit blank);
    job_t j;
    j = '{pos: pos, track: '0, digit: digit, delay: delay, silent: silent};
    if (!blank) begin
      j.track[pos + 52] = 1'b1;
      j.track[$urandom_range(TRACK_W - 1)] = 1'b1;
    end
    return j;
  endfunction

  function automatic job_t rand_job();
    job_t j;
    j.pos   = ($urandom_range(9) == 0) ? int'($urandom_range(127, 81)) : int'($urandom_range(80));
    j.track = '0;
    if ($urandom_range(5) != 0) repeat (1 + $urandom_range(20)) j.track[$urandom_range(TRACK_W - 1)] = 1'b1;
    j.digit  = ($urandom_range(3) != 0) ? int'($urandom_range(9, 1)) : int'($urandom_range(15));
    j.delay  = $urandom_range(TMO, 1);
    j.silent = ($urandom_range(7) == 0);
    return j;
  endfunction

  function automatic logic [CELLS-1:0] rand_mask();
    logic [CELLS-1:0] m;
    for (int i = 0; i < CELLS; i++) m[i] = ($urandom_range(3) == 0);
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cap(input job_t j);
    bus.cap_valid = 1'b1;
    bus.cap_pos   = POS_W'(j.pos);
    bus.cap_track = j.track;
  endtask

  task automatic loadLock(input logic [CELLS-1:0] m);
    bus.lock_load = 1'b1;
    bus.lock_mask = m;
    step();
    bus.lock_load = 1'b0;
    lock_model    = m;
  endtask

  task automatic waitQuiet();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cyc <= idle_at) && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("[TB] FAIL wait_quiet cyc=%0d got pending=%0d required 0", cyc, exp_q.size());
      exp_q.delete();
    end
    checkOutput("busy_idle", bus.busy, 0);
    checkOutput("plan_drained", plan_q.size(), 0);
  endtask

  // One capture in the current cycle, optional extra captures while busy and an optional lock reload.
  task automatic applyStimulus(input job_t j0, input job_t e1, input int off1, input job_t e2, input int off2,
                               input bit do_lock, input logic [CELLS-1:0] new_mask);
    int t, c1, c2, last;
    t = cyc;
    drive_cap(j0);
    capture_model(t, j0);
    c1 = (off1 > 0 && t + off1 < idle_at) ? t + off1 : -1;
    c2 = (off2 > off1 && t + off2 < idle_at) ? t + off2 : -1;
    last = t + 1;
    if (c1 > last) last = c1;
    if (c2 > last) last = c2;
    step();
    while (cyc <= last) begin
      bus.cap_valid = 1'b0;
      bus.lock_load = 1'b0;
      if (do_lock && cyc == t + 1) begin
        bus.lock_load = 1'b1;
        bus.lock_mask = new_mask;
      end
      if (cyc == c1) begin
        drive_cap(e1);
        capture_model(cyc, e1);
      end else if (cyc == c2) begin
        drive_cap(e2);
        capture_model(cyc, e2);
      end
      step();
    end
    bus.cap_valid = 1'b0;
    bus.lock_load = 1'b0;
    if (do_lock) lock_model = new_mask;
    drain();
    waitQuiet();
  endtask

  task automatic single(input job_t j);
    applyStimulus(j, j, 0, j, 0, 1'b0, '0);
  endtask

  task automatic resetTest();
    job_t j;
    int   t;
    t = cyc;
    j = mk(40, 5, 10, 1'b0, 1'b0);
    drive_cap(j);
    push_exp(t + 2, K_START, 40, 0, j.track);
    plan_q.push_back('{delay: 10, digit: 5, silent: 1'b0});
    step();
    bus.cap_valid = 1'b0;
    while (cyc < t + 4) step();
    drive_cap(mk(22, 2, 3, 1'b0, 1'b0));
    step();
    bus.cap_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    plan_q.delete();
    lock_model  = '0;
    slot_full_m = 1'b0;
    idle_at     = cyc;
    checkOutput("rec_track_after_reset", |bus.rec_track, 0);
    repeat (20) step();
    checkOutput("busy_after_reset", bus.busy, 0);
  endtask

  // Recognizer: answers each launch according to the plan the model queued for it.
  initial begin
    bus.rec_done  = 1'b0;
    bus.rec_digit = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.rec_start) begin
        plan_t p;
        int    d, dg;
        if (plan_q.size() > 0) p = plan_q.pop_front();
        else p = '{delay: TMO + 1, digit: 3, silent: 1'b1};
        d  = p.silent ? TMO + 1 : p.delay;
        dg = p.silent ? int'($urandom_range(9, 1)) : p.digit;
        repeat (d) @(posedge clk);
        #1;
        bus.rec_done  = 1'b1;
        bus.rec_digit = DIGIT_W'(dg);
        step();
        bus.rec_done  = 1'b0;
        bus.rec_digit = DIGIT_W'($urandom_range(15));
      end
    end
  end

  task automatic handle(input int kind, input int addr, input int data, input logic [TRACK_W-1:0] tr);
    exp_t e;
    bit   ok;
    checks++;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].kind == kind) begin
      e  = exp_q.pop_front();
      ok = 1'b1;
      if (kind == K_WR)    ok = (addr == e.addr && data == e.data);
      if (kind == K_START) ok = (tr === e.track);
      if (!ok) begin
        failures++;
        $display("[TB] FAIL event%0d cyc=%0d got addr=%0d data=%0d track_ok=%0d required addr=%0d data=%0d",
                 kind, cyc, addr, data, tr === e.track, e.addr, e.data);
      end
    end else begin
      failures++;
      $display("[TB] FAIL unexpected_event%0d cyc=%0d got present required absent", kind, cyc);
    end
  endtask

  // Monitor: every output event the DUT shows must be the next one the model predicted.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        checkOutput("reset_outputs",
                    {bus.rec_start, bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.err_range,
                     bus.err_locked, bus.err_reject, bus.err_timeout, bus.overrun}, 0);
      end else begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          checks++;
          failures++;
          $display("[TB] FAIL missing_event%0d cyc=%0d got absent required at cyc=%0d",
                   exp_q[0].kind, cyc, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
        if (bus.rec_start)   handle(K_START, 0, 0, bus.rec_track);
        if (bus.wr_en)       handle(K_WR, int'(bus.wr_addr), int'(bus.wr_data), '0);
        if (bus.err_range)   handle(K_RANGE, 0, 0, '0);
        if (bus.err_locked)  handle(K_LOCKED, 0, 0, '0);
        if (bus.err_reject)  handle(K_REJECT, 0, 0, '0);
        if (bus.err_timeout) handle(K_TIMEOUT, 0, 0, '0);
        if (bus.overrun)     handle(K_OVERRUN, 0, 0, '0);
        if (bus.wr_en)
          checkOutput("err_with_wr", {bus.err_range, bus.err_locked, bus.err_reject, bus.err_timeout}, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog cyc=%0d got no finish required finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [CELLS-1:0] m;
    job_t             z;
    rst           = 1'b1;
    bus.cap_valid = 1'b0;
    bus.cap_pos   = '0;
    bus.cap_track = '0;
    bus.lock_load = 1'b0;
    bus.lock_mask = '0;
    lock_model    = '0;
    slot_full_m   = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    idle_at = cyc;
    checkOutput("rec_track_reset", |bus.rec_track, 0);

    single(mk(40, 7, 10, 1'b0, 1'b0));
    m = '0;
    m[3] = 1'b1;
    loadLock(m);
    single(mk(3, 5, 4, 1'b0, 1'b0));
    single(mk(90, 5, 4, 1'b0, 1'b0));
    single(mk(81, 5, 4, 1'b0, 1'b0));
    single(mk(80, 9, 1, 1'b0, 1'b0));
    single(mk(5, 0, 6, 1'b0, 1'b0));
    single(mk(6, 12, 2, 1'b0, 1'b0));
    single(mk(30, 4, 1, 1'b1, 1'b0));
    single(mk(31, 4, TMO, 1'b0, 1'b0));
    applyStimulus(mk(60, 7, 10, 1'b0, 1'b0), mk(10, 3, 4, 1'b0, 1'b0), 5,
                  mk(20, 8, 5, 1'b0, 1'b0), 8, 1'b0, '0);
    m[50] = 1'b1;
    z = mk(50, 2, 3, 1'b0, 1'b0);
    applyStimulus(z, z, 0, z, 0, 1'b1, m);
    single(mk(50, 2, 3, 1'b0, 1'b0));
    single(mk(8, 6, 2, 1'b0, 1'b1));

    for (int i = 0; i < 30; i++) begin
      job_t a, b, c;
      int   o1, o2;
      a  = rand_job();
      b  = rand_job();
      c  = rand_job();
      o1 = ($urandom_range(2) == 0) ? int'($urandom_range(15, 1)) : 0;
      o2 = (o1 != 0 && $urandom_range(1) == 0) ? o1 + int'($urandom_range(6, 1)) : 0;
      if ($urandom_range(4) == 0) loadLock(rand_mask());
      applyStimulus(a, b, o1, c, o2, ($urandom_range(3) == 0), rand_mask());
    end

    resetTest();
    single(mk(3, 6, 2, 1'b0, 1'b0));
    single(mk(8, 6, 2, 1'b0, 1'b1));
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
